// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// PROG_LOADER_CHECKSUM_EN adds the trailing XOR checksum state.
package prog_loader_pkg;

    localparam logic [7:0]  MAGIC  = 8'hA5;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_e;

    // Every non-terminal state takes a byte per cycle.
    function automatic logic accepts(input state_e s);
        return !(s inside {DONE, ERROR});
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/prog_loader_word_packer.sv
// Shifts accepted bytes into a little-endian 32-bit word; flags the 4th byte.
module word_packer
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_valid_c
);

    localparam int unsigned SR_W = WORD_W - BYTE_W;

    logic [1:0]      idx_q;
    logic [SR_W-1:0] sr_q;

    // The 4th byte completes the word straight from the input.
    assign word_c       = {byte_in, sr_q};
    assign word_valid_c = byte_en && (idx_q == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            sr_q  <= '0;
        end else if (byte_en) begin
            idx_q <= idx_q + 2'd1;
            sr_q  <= {byte_in, sr_q[SR_W-1:BYTE_W]};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a framed firmware image into core memory, holding the core in reset.
// Optional trailing checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    prog_loader_if.slave      bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned LIMIT = (1 << ADDR_W) - BASE_ADDR;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_e AFTER_DATA = CSUM;
`else
    localparam state_e AFTER_DATA = DONE;
`endif

    state_e             state_q, state_nxt;
    logic               in_ready_q;
    logic [LEN_W-1:0]   len_q;
    logic [IDX_W-1:0]   widx_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  csum_q;
`endif

    logic               accept_c;
    logic               pack_en_c;
    logic               word_valid_c;
    logic               last_word_c;
    logic [WORD_W-1:0]  word_c;
    logic [LEN_W-1:0]   len_full_c;

    assign bus.in_ready = in_ready_q;
    assign accept_c     = bus.in_valid && in_ready_q;
    assign pack_en_c    = accept_c && (state_q == DATA);
    assign len_full_c   = {bus.in_data, len_q[BYTE_W-1:0]};
    assign last_word_c  = (32'(widx_q) + 32'd1) == 32'(len_q);

    word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .byte_en      (pack_en_c),
        .byte_in      (bus.in_data),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

    // Frame parser: advances only on accepted bytes.
    always_comb begin
        state_nxt = state_q;
        if (accept_c) begin
            unique case (state_q)
                IDLE:    if (bus.in_data == MAGIC) state_nxt = LEN_LO;
                LEN_LO:  state_nxt = LEN_HI;
                LEN_HI: begin
                    if (32'(len_full_c) > LIMIT) state_nxt = ERROR;
                    else if (len_full_c == '0)   state_nxt = AFTER_DATA;
                    else                         state_nxt = DATA;
                end
                DATA:    if (word_valid_c && last_word_c) state_nxt = AFTER_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM:    state_nxt = (bus.in_data == csum_q) ? DONE : ERROR;
`endif
                default: state_nxt = state_q;
            endcase
        end
    end

    // State register, write port, length/index/checksum and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len_q      <= '0;
            widx_q     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= accepts(state_nxt);
            mem_we     <= word_valid_c;
            if (word_valid_c) begin
                mem_addr  <= ADDR_W'(BASE_ADDR + 32'(widx_q));
                mem_wdata <= word_c;
                widx_q    <= widx_q + IDX_W'(1);
            end
            if (accept_c && state_q == LEN_LO) len_q[BYTE_W-1:0] <= bus.in_data;
            if (accept_c && state_q == LEN_HI) len_q <= len_full_c;
`ifdef PROG_LOADER_CHECKSUM_EN
            if (pack_en_c) csum_q <= csum_q ^ bus.in_data;
`endif
            // Release lags DONE by a cycle so it always follows the last write.
            core_reset <= (state_q != DONE);
            done       <= (state_q == DONE);
            error      <= (state_nxt == ERROR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized directed bench for prog_loader against a frame-level reference model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned BASE_ADDR = 0;
    localparam int          DEPTH     = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;

    prog_loader_if bus ();

    prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  stim[$];
    wr_t         exp_q[$];
    wr_t         got_q[$];
    bit          exp_done;
    bit          exp_err;
    int          we_with_done = 0;

    // Capture each write pulse; a stretched pulse shows up as an extra write.
    always @(negedge clk) begin
        if (reset && mem_we) begin
            wr_t w;
            w.addr = mem_addr;
            w.data = mem_wdata;
            got_q.push_back(w);
            if (done) we_with_done++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: parse the byte list by the frame rules into expected writes and status.
    task automatic model_run();
        int i;
        int n;
        logic [31:0] word;
        wr_t w;
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        i = 0;
        while (i < stim.size() && stim[i] != MAGIC) i++;
        if (i + 2 >= stim.size()) return;
        n = int'(stim[i+1]) + 256 * int'(stim[i+2]);
        i += 3;
        if (n > DEPTH - int'(BASE_ADDR)) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (i + 4 > stim.size()) return;
            word = 32'(stim[i]) + (32'(stim[i+1]) * 256) + (32'(stim[i+2]) * 65536)
                 + (32'(stim[i+3]) * 16777216);
`ifdef PROG_LOADER_CHECKSUM_EN
            x = x ^ stim[i] ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
`endif
            w.addr = ADDR_W'((int'(BASE_ADDR) + k) % DEPTH);
            w.data = word;
            exp_q.push_back(w);
            i += 4;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (i >= stim.size()) return;
        if (stim[i] == x) exp_done = 1'b1;
        else              exp_err  = 1'b1;
`else
        exp_done = 1'b1;
`endif
    endtask

    task automatic add_frame(input int n);
        logic [7:0] b;
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        stim.push_back(MAGIC);
        stim.push_back(8'(n));
        stim.push_back(8'(n >> 8));
        repeat (4 * n) begin
            b = 8'($urandom);
            stim.push_back(b);
`ifdef PROG_LOADER_CHECKSUM_EN
            x = x ^ b;
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        stim.push_back(x);
`endif
    endtask

    // Called at a negedge; returns at the negedge after the byte's clock edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stim(input int gap_max);
        foreach (stim[i])
            send_byte(stim[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
    endtask

    task automatic reset_dut(input string tag);
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk({tag, ".ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, ".we"},    64'(mem_we),       64'd0);
        chk({tag, ".addr"},  64'(mem_addr),     64'd0);
        chk({tag, ".wdata"}, 64'(mem_wdata),    64'd0);
        chk({tag, ".crst"},  64'(core_reset),   64'd1);
        chk({tag, ".done"},  64'(done),         64'd0);
        chk({tag, ".err"},   64'(error),        64'd0);
        @(negedge clk);
        reset = 1'b1;
        got_q.delete();
        we_with_done = 0;
    endtask

    task automatic check_result(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, ".nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i])
            if (i < got_q.size()) chk({tag, ".wr"}, 64'(got_q[i]), 64'(exp_q[i]));
        if (exp_q.size() > 0) begin
            chk({tag, ".addr_hold"},  64'(mem_addr),  64'(exp_q[exp_q.size()-1].addr));
            chk({tag, ".wdata_hold"}, 64'(mem_wdata), 64'(exp_q[exp_q.size()-1].data));
        end
        chk({tag, ".done"},    64'(done),         64'(exp_done));
        chk({tag, ".err"},     64'(error),        64'(exp_err));
        chk({tag, ".crst"},    64'(core_reset),   64'(!exp_done));
        chk({tag, ".ready"},   64'(bus.in_ready), 64'(!(exp_done || exp_err)));
        chk({tag, ".we_done"}, 64'(we_with_done), 64'd0);
        got_q.delete();
        we_with_done = 0;
    endtask

    initial begin
        logic [7:0] tp[11];
        logic [7:0] g;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset_dut("rst0");

        // Reference image from the bring-up notes.
        tp = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        stim.delete();
        foreach (tp[i]) stim.push_back(tp[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
        g = 8'h00;
        for (int i = 3; i < 11; i++) g = g ^ tp[i];
        stim.push_back(g);
`endif
        model_run();
        chk("tp.w0", 64'(exp_q[0].data), 64'h00A00513);
        send_stim(0);
`ifndef PROG_LOADER_CHECKSUM_EN
        chk("tp.we_last", 64'(mem_we), 64'd1);
`endif
        chk("tp.done_early",  64'(done),         64'd0);
        chk("tp.crst_early",  64'(core_reset),   64'd1);
        chk("tp.ready_off",   64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("tp.done_late",   64'(done),         64'd1);
        chk("tp.crst_late",   64'(core_reset),   64'd0);
        send_byte(8'h5A, 0);
        check_result("tp");

        // Garbage ahead of a one-word frame.
        reset_dut("rst1");
        stim = '{8'h00, 8'hFF, 8'h12};
        add_frame(1);
        model_run();
        send_stim(0);
        check_result("garbage");

        // One word past the memory depth.
        reset_dut("rst2");
        stim = '{8'hA5, 8'h01, 8'h04};
        model_run();
        send_stim(0);
        chk("len_over.err_now",   64'(error),        64'd1);
        chk("len_over.ready_now", 64'(bus.in_ready), 64'd0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        check_result("len_over");

        // Exactly the memory depth.
        reset_dut("rst3");
        stim.delete();
        add_frame(DEPTH - int'(BASE_ADDR));
        model_run();
        send_stim(0);
        check_result("len_max");

        // Empty image.
        reset_dut("rst4");
        stim.delete();
        add_frame(0);
        model_run();
        send_stim(0);
        check_result("len_zero");

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum off by one bit.
        reset_dut("rst5");
        stim.delete();
        add_frame(1);
        stim[stim.size()-1] = stim[stim.size()-1] ^ 8'h04;
        model_run();
        send_stim(0);
        check_result("bad_csum");
`endif

        // Stall of 7 cycles between payload bytes 2 and 3.
        reset_dut("rst6");
        stim.delete();
        add_frame(1);
        model_run();
        foreach (stim[i]) send_byte(stim[i], (i == 5) ? 7 : 0);
        check_result("stall");

        // Reset in the middle of a word, then a fresh frame.
        reset_dut("rst7");
        stim = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD};
        send_stim(0);
        reset_dut("rst_mid");
        stim.delete();
        add_frame(1);
        model_run();
        send_stim(0);
        check_result("after_rst");

        // Random frames with random garbage and gaps.
        for (int t = 0; t < 6; t++) begin
            reset_dut("rst_rand");
            stim.delete();
            repeat ($urandom_range(3, 0)) begin
                g = 8'($urandom);
                stim.push_back((g == MAGIC) ? 8'h5A : g);
            end
            add_frame(int'($urandom_range(8, 1)));
            model_run();
            send_stim(3);
            check_result("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
